core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the 9-bit, 3-bit-opcode core.
//  Latches instruction-ROM output, steps FETCH->DECODE->EXEC->(MEM)->WB, owns the program counter.
//  Gates the control decoder's RegWrite/MemWrite into single-cycle write strobes.
//  Signals done on the halt word or PC exhaustion. Sits between instruction ROM, control decoder and datapath.
// PARAMETERS
//  PC_W      10      program counter width; ROM depth = 2**PC_W
//  INSTR_W   9       instruction word width
//  OP_W      3       opcode width, taken from instr_q[INSTR_W-1 -: OP_W]
//  HALT_WORD 9'h1FF  instruction word that terminates the program
//  CNT_W     16      width of the saturating cycle counter
// PORTS
//  clk          in   1        single clock; all state updates on posedge
//  reset        in   1        synchronous, active-high
//  start        in   1        sampled in IDLE/DONE only; launches program from pc 0
//  instr_in     in   INSTR_W  instruction-ROM data at address prog_ctr (combinational ROM)
//  ctl_branch   in   1        decoder Branch for instr_q
//  ctl_memwrite in   1        decoder MemWrite for instr_q
//  ctl_memtoreg in   1        decoder MemtoReg for instr_q (1 = load)
//  ctl_regwrite in   1        decoder RegWrite for instr_q
//  alu_zero     in   1        datapath zero flag, valid in WB
//  br_target    in   PC_W     absolute branch target, valid in WB
//  prog_ctr     out  PC_W     instruction-ROM address
//  instr_q      out  INSTR_W  instruction register, drives decoder and datapath
//  reg_we       out  1        register-file write strobe
//  mem_we       out  1        data-memory write strobe
//  busy         out  1        high in FETCH..WB
//  done         out  1        high in DONE
//  cycle_cnt    out  CNT_W    cycles spent in FETCH..WB for the current run
// BEHAVIOUR
//  Reset: state=IDLE, prog_ctr=0, instr_q=0, cycle_cnt=0.
//   reg_we, mem_we, busy, done all 0. Reset wins over every other event, in any state.
//  States:
//   IDLE:   start=1 -> FETCH with prog_ctr=0, cycle_cnt=0.
//   FETCH:  instr_q<=instr_in -> DECODE.
//   DECODE: instr_q==HALT_WORD -> DONE; else -> EXEC.
//   EXEC:   ctl_memwrite|ctl_memtoreg -> MEM; else -> WB.
//   MEM:    mem_we=ctl_memwrite (exactly one cycle); load read completes -> WB.
//   WB:     reg_we=ctl_regwrite (exactly one cycle); PC update (below) -> FETCH,
//           or -> DONE on PC exhaustion.
//   DONE:   done=1, prog_ctr and cycle_cnt hold; start=1 -> FETCH, prog_ctr=0, cycle_cnt=0.
//  PC update in WB:
//   - taken = ctl_branch & ~alu_zero (BNE); taken -> prog_ctr<=br_target, else prog_ctr+1.
//   - Untaken at prog_ctr == 2**PC_W-1: no wrap -> DONE, prog_ctr holds.
//   - Taken branch at the last address is legal and goes to FETCH.
//  Strobes: reg_we, mem_we, busy and done decode from the state register (no extra latency).
//   Never both 1 in one cycle; both 0 in every other state.
//  Latency: ALU instr 4 cycles, load/store 5, halt 2 (FETCH, DECODE).
//  cycle_cnt: +1 each cycle in FETCH..WB, saturates at all-ones.
//  start: ignored while busy; start held high in DONE relaunches on the next edge.
// STRUCTURE
//  seq_pkg holds:
//   - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
//   - opcode localparams: OP_ADD=000 OP_ROR=001 OP_NAND=010 OP_LOAD=011
//     OP_STORE=100 OP_MOV=101 OP_BNE=110 OP_SET=111.
//   - HALT_WORD default.
//  One sub-module, prog_counter: holds PC; load/increment/hold controls;
//   end-of-range flag at 2**PC_W-1.
// TESTING
//  1. ROM={ADD,ADD,HALT}, start pulse -> prog_ctr 0,1,2; reg_we 2 pulses; done at cycle 10; cycle_cnt=10.
//  2. ROM={STORE,HALT} -> mem_we high exactly 1 cycle (MEM); reg_we never high; cycle_cnt=7.
//  3. BNE at pc 3, br_target=5: alu_zero=0 -> next fetch at 5; alu_zero=1 -> next fetch at 4.
//  4. PC_W=3, ROM of 8 ADDs, no halt -> DONE after pc 7 WB; prog_ctr holds 7; done=1.
//  5. reset asserted in MEM of a STORE -> next cycle IDLE; mem_we=0; prog_ctr=0; no further strobes.
//  6. start pulsed mid-run -> ignored; start held high in DONE -> restart at pc 0; cycle_cnt cleared.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_sequencer_pkg;

    // Sequencer phases; FETCH..WB form the busy window.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Opcode field values of the 9-bit instruction word.
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ROR   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_MOV   = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_SET   = 3'b111;

    // Instruction word that ends a program.
    localparam logic [8:0] HALT_WORD_DEF = 9'h1FF;

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle of ROM, decoder and datapath signals around the sequencer.
interface core_sequencer_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [INSTR_W-1:0] instr_in;
    logic               ctl_branch;
    logic               ctl_memwrite;
    logic               ctl_memtoreg;
    logic               ctl_regwrite;
    logic               alu_zero;
    logic [PC_W-1:0]    br_target;
    logic [PC_W-1:0]    prog_ctr;
    logic [INSTR_W-1:0] instr_q;
    logic               reg_we;
    logic               mem_we;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cycle_cnt;

    // Environment side: ROM, decoder, datapath and the launching agent.
    modport master (
        output start, instr_in, ctl_branch, ctl_memwrite, ctl_memtoreg,
               ctl_regwrite, alu_zero, br_target,
        input  prog_ctr, instr_q, reg_we, mem_we, busy, done, cycle_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, instr_in, ctl_branch, ctl_memwrite, ctl_memtoreg,
               ctl_regwrite, alu_zero, br_target,
        output prog_ctr, instr_q, reg_we, mem_we, busy, done, cycle_cnt
    );
endinterface

// File: rtl/core_sequencer_prog_counter.sv
// Program counter with clear/load/increment controls and a last-address flag.
module core_sequencer_prog_counter #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_load_val,
    output logic [PC_W-1:0] o_pc,
    output logic            o_at_end
);
    logic [PC_W-1:0] r_pc;

    // Clear beats load beats increment; otherwise the PC holds.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_pc <= '0;
        end else if (i_clear) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc     = r_pc;
    assign o_at_end = (r_pc == {PC_W{1'b1}});
endmodule

// File: rtl/core_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC and instruction register,
// turns decoder write enables into one-cycle strobes, counts busy cycles.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter int                 OP_W      = 3,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF,
    parameter int                 CNT_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    core_sequencer_if.slave bus
);
    // The opcode is taken from the top OP_W bits, so it must fit in the word.
    if (OP_W > INSTR_W) begin : g_bad_op_w
        $error("OP_W must not exceed INSTR_W");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [PC_W-1:0]    w_pc;
    logic               w_pc_at_end;
    logic               w_launch;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic               w_taken;
    logic               w_busy;

    core_sequencer_prog_counter #(.PC_W(PC_W)) u_prog_counter (
        .clk        (clk),
        .srst       (reset),
        .i_clear    (w_launch),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_load_val (bus.br_target),
        .o_pc       (w_pc),
        .o_at_end   (w_pc_at_end)
    );

    // BNE semantics: branch taken when the compared values differ.
    assign w_taken = bus.ctl_branch & ~bus.alu_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and PC control; start is only honoured while idle or done.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next = FETCH;
                    w_launch     = 1'b1;
                end
            end
            FETCH:  w_state_next = DECODE;
            DECODE: w_state_next = (r_instr == HALT_WORD) ? DONE : EXEC;
            EXEC:   w_state_next = (bus.ctl_memwrite | bus.ctl_memtoreg) ? MEM : WB;
            MEM:    w_state_next = WB;
            WB: begin
                if (w_taken) begin
                    w_pc_load    = 1'b1;
                    w_state_next = FETCH;
                end else if (w_pc_at_end) begin
                    // No wrap past the last ROM address: the program is over.
                    w_state_next = DONE;
                end else begin
                    w_pc_inc     = 1'b1;
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Instruction register captures the ROM word during FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= '0;
        end else if (r_state == FETCH) begin
            r_instr <= bus.instr_in;
        end
    end

    // Busy-cycle counter: cleared on launch, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_launch) begin
            r_cycle_cnt <= '0;
        end else if (w_busy && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign w_busy        = (r_state == FETCH) || (r_state == DECODE) ||
                           (r_state == EXEC)  || (r_state == MEM)    ||
                           (r_state == WB);
    assign bus.busy      = w_busy;
    assign bus.done      = (r_state == DONE);
    assign bus.mem_we    = (r_state == MEM) & bus.ctl_memwrite;
    assign bus.reg_we    = (r_state == WB)  & bus.ctl_regwrite;
    assign bus.prog_ctr  = w_pc;
    assign bus.instr_q   = r_instr;
    assign bus.cycle_cnt = r_cycle_cnt;
endmodule
